// File: rtl/spi_slave_regs.sv
// SPI responder for 25-bit mode-0 frames {rw, addr[3:0], data[19:0]} backed by a 16 x 20-bit register file.
// Define SPI_SLV_RO_ID_EN to make address 15 a read-only ID register returning ID_VALUE.
module spi_slave_regs #(
  parameter int                ADDR_W      = 4,
  parameter int                DATA_W      = 20,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = 20'hA5C3E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err
);

  localparam int REGS      = 2 ** ADDR_W;
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CMD = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ID_ADDR  = '1;

`ifdef SPI_SLV_RO_ID_EN
  localparam bit RO_ID = 1'b1;
`else
  localparam bit RO_ID = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_DATA, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [ADDR_W-1:0]      cmd_shift;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [DATA_W-1:0]      rx_data;
  logic [DATA_W-1:0]      tx_shift;
  logic                   wr_pend;
  logic [DATA_W-1:0]      regfile [REGS];

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [ADDR_W:0]        cmd_next;
  logic [DATA_W-1:0]      tx_word, loc_word;

  // cs_n resets to a low sample so a frame already in progress when reset releases
  // never produces a falling edge; the bus is ignored until cs_n is seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  always_comb begin
    cmd_next = {cmd_shift, mosi_s};
    tx_word  = regfile[cmd_next[ADDR_W-1:0]];
    loc_word = regfile[loc_addr];
    if (RO_ID && cmd_next[ADDR_W-1:0] == ID_ADDR) tx_word  = ID_VALUE;
    if (RO_ID && loc_addr == ID_ADDR)             loc_word = ID_VALUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_shift <= '0;
      cmd_addr  <= '0;
      rx_data   <= '0;
      tx_shift  <= '0;
      wr_pend   <= 1'b0;
      // NOTE: the register file is small and must read as zero after reset, so it is
      // built from flops with a reset rather than inferred as RAM.
      regfile   <= '{default: '0};
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      loc_rdata <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      // NOTE: non-blocking reads here see the pre-write regfile, so a same-cycle
      // local read of the address being committed returns the old value.
      loc_rdata <= loc_word;

      if (wr_pend) begin
        wr_pend  <= 1'b0;
        if (!(RO_ID && cmd_addr == ID_ADDR)) regfile[cmd_addr] <= rx_data;
        wr_pulse <= 1'b1;
        wr_addr  <= cmd_addr;
        wr_data  <= rx_data;
      end

      if (cs_rise && (state == CMD || state == WR_DATA || state == RD_DATA)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        miso_oe   <= 1'b0;
        miso      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            if (cs_fall) begin
              bit_cnt <= '0;
              state   <= CMD;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_shift <= cmd_next[ADDR_W-1:0];
              bit_cnt   <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_CMD) begin
                cmd_addr <= cmd_next[ADDR_W-1:0];
                if (cmd_next[ADDR_W]) begin
                  tx_shift <= tx_word;
                  miso_oe  <= 1'b1;
                  state    <= RD_DATA;
                end else begin
                  state <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (sclk_rise) begin
              rx_data <= {rx_data[DATA_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state   <= DONE;
                wr_pend <= 1'b1;
              end
            end
          end
          RD_DATA: begin
            // Each fall presents the current MSB and advances the snapshot.
            if (sclk_fall) begin
              miso     <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state   <= DONE;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
              end
            end
          end
          DONE: begin
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            if (cs_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: directed scenarios plus randomized frames checked
// against an array model of the register file.
module tb_spi_slave_regs;

  localparam int HALF = 4;  // sclk half period in clk cycles (sclk = clk/8)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [3:0]  loc_addr = 4'd0;
  logic        miso, miso_oe, wr_pulse, frame_err;
  logic [19:0] loc_rdata, wr_data;
  logic [3:0]  wr_addr;

  always #10 clk = ~clk;

  spi_slave_regs dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] model_regs [16];

  // Output monitor, sampled on the falling clk edge.
  int          pulse_cnt = 0;
  int          ferr_cnt = 0;
  int          miso_bad = 0;
  logic [3:0]  last_wa = '0;
  logic [19:0] last_wd = '0;
  logic [19:0] loc_at_pulse = '0;
  logic [19:0] loc_after = '0;
  bit          grab_next = 1'b0;

  always @(negedge clk) begin
    if (wr_pulse) begin
      pulse_cnt    <= pulse_cnt + 1;
      last_wa      <= wr_addr;
      last_wd      <= wr_data;
      loc_at_pulse <= loc_rdata;
      grab_next    <= 1'b1;
    end else if (grab_next) begin
      loc_after <= loc_rdata;
      grab_next <= 1'b0;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (!miso_oe && miso) miso_bad <= miso_bad + 1;
  end

  function automatic logic [19:0] model_read(input logic [3:0] a);
`ifdef SPI_SLV_RO_ID_EN
    if (a == 4'hF) return 20'hA5C3E;
`endif
    return model_regs[a];
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [19:0] d);
`ifdef SPI_SLV_RO_ID_EN
    if (a == 4'hF) return;
`endif
    model_regs[a] = d;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk pulse: drive mosi, sample miso/miso_oe at the end of the low phase, then rise and fall.
  task automatic pulse_bit(input logic b, output logic m, output logic oe);
    mosi = b;
    wait_clks(HALF);
    m  = miso;
    oe = miso_oe;
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  // Full master transaction with npulses sclk pulses; bits past 25 are zero-filled.
  task automatic spi_frame(input logic rw, input logic [3:0] a, input logic [19:0] d,
                           input int npulses, output logic [19:0] rx, output int oe_bad);
    logic [24:0] frame;
    logic        m, oe, exp_oe;
    frame  = {rw, a, d};
    rx     = '0;
    oe_bad = 0;
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < npulses; i++) begin
      pulse_bit((i < 25) ? frame[24-i] : 1'b0, m, oe);
      exp_oe = rw && (i >= 5) && (i <= 24);
      if (oe !== exp_oe) oe_bad++;
      if (i >= 5 && i <= 24) rx[24-i] = m;
    end
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic check_loc(input logic [3:0] a, input string name);
    logic [19:0] exp;
    exp = model_read(a);
    loc_addr = a;
    wait_clks(1);
    vectors++;
    if (loc_rdata !== exp) begin
      miscompares++;
      $display("FAIL %s: loc_rdata[%0d] got %h expected %h", name, a, loc_rdata, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({miso, miso_oe, wr_pulse, frame_err, wr_addr, wr_data, loc_rdata} !== '0) begin
      miscompares++;
      $display("FAIL %s: miso=%b oe=%b wr_pulse=%b ferr=%b wr_addr=%h wr_data=%h loc=%h expected all 0",
               name, miso, miso_oe, wr_pulse, frame_err, wr_addr, wr_data, loc_rdata);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    rst = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(1);
    check_outputs_zero("reset_outputs");
    check_loc(4'd0, "reset_loc0");
    check_loc(4'd9, "reset_loc9");
  endtask

  task automatic test_write_read();
    logic [19:0] rx;
    int          ob, p0, f0;
    p0 = pulse_cnt;
    spi_frame(1'b0, 4'd3, 20'h12345, 25, rx, ob);
    model_write(4'd3, 20'h12345);
    vectors++;
    if (pulse_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL wr_pulse_count: got %0d expected 1", pulse_cnt - p0);
    end
    vectors++;
    if (last_wa !== 4'd3 || last_wd !== 20'h12345) begin
      miscompares++;
      $display("FAIL wr_addr_data: got %h/%h expected 3/12345", last_wa, last_wd);
    end
    check_loc(4'd3, "loc_after_write");
    f0 = ferr_cnt;
    spi_frame(1'b1, 4'd3, 20'h0, 25, rx, ob);
    vectors++;
    if (rx !== 20'h12345) begin
      miscompares++;
      $display("FAIL spi_read3: got %h expected 12345", rx);
    end
    vectors++;
    if (ob !== 0 || ferr_cnt !== f0 || miso_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL read_oe_window: oe_errors=%0d frame_err=%0d oe_end=%b expected 0/0/0",
               ob, ferr_cnt - f0, miso_oe);
    end
  endtask

  task automatic test_abort();
    logic [19:0] rx;
    int          ob, p0, f0;
    spi_frame(1'b0, 4'd7, 20'hFFFFF, 25, rx, ob);
    model_write(4'd7, 20'hFFFFF);
    p0 = pulse_cnt;
    f0 = ferr_cnt;
    spi_frame(1'b0, 4'd7, 20'h00000, 17, rx, ob);
    vectors++;
    if (ferr_cnt - f0 !== 1 || pulse_cnt !== p0) begin
      miscompares++;
      $display("FAIL abort_pulses: frame_err=%0d wr_pulse=%0d expected 1/0", ferr_cnt - f0, pulse_cnt - p0);
    end
    check_loc(4'd7, "abort_reg7_kept");
  endtask

  task automatic test_reset_mid();
    logic [19:0] rx;
    logic [24:0] frame;
    logic        m, oe;
    int          ob, p0, f0;
    spi_frame(1'b0, 4'd5, 20'h2468A, 25, rx, ob);
    model_write(4'd5, 20'h2468A);
    loc_addr = 4'd5;
    frame = {1'b0, 4'd5, 20'h77777};
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 15; i++) pulse_bit(frame[24-i], m, oe);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    wait_clks(1);
    check_outputs_zero("reset_mid_outputs");
    p0 = pulse_cnt;
    f0 = ferr_cnt;
    for (int i = 15; i < 25; i++) pulse_bit(frame[24-i], m, oe);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(8);
    vectors++;
    if (pulse_cnt !== p0 || ferr_cnt !== f0) begin
      miscompares++;
      $display("FAIL reset_mid_ignored: wr_pulse=%0d frame_err=%0d expected 0/0", pulse_cnt - p0, ferr_cnt - f0);
    end
    check_loc(4'd5, "reset_mid_reg5_cleared");
    spi_frame(1'b0, 4'd5, 20'h0ABCD, 25, rx, ob);
    model_write(4'd5, 20'h0ABCD);
    vectors++;
    if (pulse_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL reset_mid_rewrite_pulse: got %0d expected 1", pulse_cnt - p0);
    end
    check_loc(4'd5, "reset_mid_reg5_new");
    check_loc(4'd3, "reset_mid_reg3_cleared");
  endtask

  task automatic test_extra_pulses();
    logic [19:0] rx;
    int          ob, p0;
    p0 = pulse_cnt;
    spi_frame(1'b0, 4'd2, 20'h54321, 30, rx, ob);
    model_write(4'd2, 20'h54321);
    vectors++;
    if (pulse_cnt - p0 !== 1 || last_wd !== 20'h54321 || last_wa !== 4'd2) begin
      miscompares++;
      $display("FAIL extra_pulses_commit: pulses=%0d addr=%h data=%h expected 1/2/54321",
               pulse_cnt - p0, last_wa, last_wd);
    end
    spi_frame(1'b1, 4'd2, 20'h0, 25, rx, ob);
    vectors++;
    if (rx !== model_read(4'd2) || ob !== 0) begin
      miscompares++;
      $display("FAIL extra_pulses_readback: got %h oe_errors=%0d expected %h/0", rx, ob, model_read(4'd2));
    end
  endtask

  task automatic test_ro_id();
    logic [19:0] rx;
    int          ob, p0;
    p0 = pulse_cnt;
    spi_frame(1'b0, 4'hF, 20'h11111, 25, rx, ob);
    model_write(4'hF, 20'h11111);
    vectors++;
    if (pulse_cnt - p0 !== 1 || last_wa !== 4'hF || last_wd !== 20'h11111) begin
      miscompares++;
      $display("FAIL addr15_write_pulse: pulses=%0d addr=%h data=%h expected 1/f/11111",
               pulse_cnt - p0, last_wa, last_wd);
    end
    spi_frame(1'b1, 4'hF, 20'h0, 25, rx, ob);
    vectors++;
    if (rx !== model_read(4'hF)) begin
      miscompares++;
      $display("FAIL addr15_spi_read: got %h expected %h", rx, model_read(4'hF));
    end
    check_loc(4'hF, "addr15_loc_read");
  endtask

  task automatic test_random();
    logic [19:0] rx, d, old_v, new_v;
    logic [3:0]  a;
    logic        rw;
    int          ob, p0, f0;
    for (int n = 0; n < 40; n++) begin
      rw = $urandom_range(1, 0) == 1;
      a  = 4'($urandom_range(15, 0));
      case ($urandom_range(3, 0))
        0:       d = 20'h00000;
        1:       d = 20'hFFFFF;
        default: d = 20'($urandom);
      endcase
      loc_addr = a;
      p0 = pulse_cnt;
      f0 = ferr_cnt;
      if (rw) begin
        spi_frame(1'b1, a, 20'h0, 25, rx, ob);
        vectors++;
        if (rx !== model_read(a) || ob !== 0 || ferr_cnt !== f0 || pulse_cnt !== p0) begin
          miscompares++;
          $display("FAIL rand_read[%0d] addr %h: got %h oe_errors=%0d ferr=%0d pulses=%0d expected %h/0/0/0",
                   n, a, rx, ob, ferr_cnt - f0, pulse_cnt - p0, model_read(a));
        end
      end else begin
        old_v = model_read(a);
        spi_frame(1'b0, a, d, 25, rx, ob);
        model_write(a, d);
        new_v = model_read(a);
        vectors++;
        if (pulse_cnt - p0 !== 1 || last_wa !== a || last_wd !== d) begin
          miscompares++;
          $display("FAIL rand_write[%0d]: pulses=%0d addr=%h data=%h expected 1/%h/%h",
                   n, pulse_cnt - p0, last_wa, last_wd, a, d);
        end
        vectors++;
        if (loc_at_pulse !== old_v || loc_after !== new_v) begin
          miscompares++;
          $display("FAIL rand_collision[%0d] addr %h: same-cycle %h next %h expected %h/%h",
                   n, a, loc_at_pulse, loc_after, old_v, new_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_reset_mid();
    test_extra_pulses();
    test_ro_id();
    test_random();
    vectors++;
    if (miso_bad !== 0) begin
      miscompares++;
      $display("FAIL miso_idle_low: %0d cycles with miso=1 while miso_oe=0, expected 0", miso_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
SPI responder (slave) for the 25-bit frames issued by the team's SPI master: 1 rw bit, 4-bit address, 20-bit data, MSB first, mode 0 (CPOL=0, CPHA=0). The block holds a 16 x 20-bit register file that the master writes and reads over SPI, and exposes a local read port plus status pulses to on-chip logic. SCK, CS_N and MOSI are oversampled in the system clock domain. There is no second clock.

Parameters:
ADDR_W, 4, register address width (16 registers)
DATA_W, 20, register / frame data width
SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (min 2)
ID_VALUE, 20'hA5C3E, read-only value at address 15 when SPI_SLV_RO_ID_EN is defined

Ports:
clk  in  1  system clock, 50 MHz; sclk must not exceed clk/8
rst  in  1  synchronous reset, active-high
sclk  in  1  SPI clock from master, asynchronous
cs_n  in  1  SPI chip select, active-low, asynchronous
mosi  in  1  SPI data from master, asynchronous
miso  out  1  SPI data to master
miso_oe  out  1  tri-state enable for miso; 1 only while a read data phase is active
loc_addr  in  4  local read address
loc_rdata  out  20  registered local read data, regfile[loc_addr], 1-cycle latency
wr_pulse  out  1  1-cycle pulse when an SPI write commits
wr_addr  out  4  address of the last committed write
wr_data  out  20  data of the last committed write
frame_err  out  1  1-cycle pulse when cs_n rises mid-frame

Behaviour:
- Reset (rst=1 at a clk edge) clears the state machine to IDLE, the bit counter, the shift registers, all 16 registers, miso, miso_oe, wr_pulse, wr_addr, wr_data, frame_err and loc_rdata. Reset mid-frame abandons the frame without a write. The block then ignores the bus until cs_n is seen high.
- sclk, cs_n and mosi pass through SYNC_STAGES flops. The rise and fall of sclk are detected from the last two synchronized samples. mosi is sampled on the detected rise.
- State IDLE: miso_oe=0. On synchronized cs_n falling, clear bit_cnt and go to CMD.
- State CMD: shift in 5 bits on sclk rises (rw first, then addr[3] down to addr[0]).
  - After the 5th rise with rw=0, go to WR_DATA.
  - After the 5th rise with rw=1, load tx_shift from regfile[addr], set miso_oe=1 and go to RD_DATA. miso presents tx_shift[19] on the next sclk fall.
- State WR_DATA: shift in 20 bits on sclk rises. On the 20th rise, go to DONE and write regfile[addr] <= rx_data in the following clk cycle. In that same cycle, assert wr_pulse for one cycle and update wr_addr and wr_data.
- State RD_DATA: on each sclk fall, shift tx_shift left and drive its MSB on miso. Bit 19 goes out on the fall after the 5th rise; bit 0 is valid across the 25th rise. After the 25th rise, go to DONE.
- State DONE: miso_oe=0. Further sclk edges are ignored. Go to IDLE when cs_n is seen high.
- cs_n rising in CMD, WR_DATA or RD_DATA: go to IDLE, pulse frame_err for one cycle, no register write, miso_oe=0 in the same cycle.
- A local read and an SPI write to the same address in the same cycle: loc_rdata returns the old value. The new value appears on the next cycle.
- The SPI read snapshot is taken at the 5th rise. A write committing later does not alter bits already in flight.
- miso=0 whenever miso_oe=0.

Optional Feature:
- Macro SPI_SLV_RO_ID_EN.
- Defined: address 15 is read-only and always reads ID_VALUE over both SPI and the local port. An SPI write to address 15 completes the frame normally and pulses wr_pulse with wr_addr=15, but leaves the register unchanged.
- Undefined: address 15 is an ordinary read/write register.

Test Plan:
- Reset, then SPI write rw=0, addr=3, data=20'h12345 at sclk=clk/8 -> wr_pulse once; wr_addr=3, wr_data=20'h12345; loc_addr=3 gives loc_rdata=20'h12345 one cycle later.
- After the write above, SPI read rw=1, addr=3 -> master captures 20'h12345 on the 20 data rises; miso_oe high only from the 5th fall to DONE; frame_err=0.
- Write addr=7 with 20'hFFFFF, then deassert cs_n after 12 bits of a write to addr=7 with 20'h00000 -> frame_err pulse, no wr_pulse, register 7 remains 20'hFFFFF.
- Assert rst during the data phase of a write to addr=5 -> register 5 = 0, all outputs 0; the next full frame writing 20'h0ABCD to addr 5 succeeds.
- 30 sclk pulses in one frame writing 20'h54321 to addr=2 -> write commits once after bit 25; extra pulses are ignored; cs_n high returns the block to IDLE.
- With SPI_SLV_RO_ID_EN defined, write 20'h11111 to addr=15, then read it -> read returns 20'hA5C3E; without the macro the read returns 20'h11111.
